// File: rtl/toy_bpu_tage_tx_table_ager_if.sv
`default_nettype none
// ============================================================================
//  Module   : toy_bpu_tage_tx_table_ager_if
//  Brief    : Requester, age-control and SRAM-side bus bundle for the TAGE
//             tagged-table ager. The slave modport is the ager's view; the
//             master modport is the view of the logic driving it.
//  Revision : 1.0 - initial release
// ============================================================================
interface toy_bpu_tage_tx_table_ager_if #(
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH   = 9,
    parameter int PRED_WIDTH  = 3,
    parameter int U_WIDTH     = 2
);
    // age control
    logic                   age_req;
    logic                   age_busy;
    logic                   age_drop;
    // requester access
    logic                   req_vld;
    logic                   req_wren;
    logic [INDEX_WIDTH-1:0] req_addr;
    logic [TAG_WIDTH-1:0]   req_wtag;
    logic [PRED_WIDTH-1:0]  req_wpred;
    logic                   req_wvalid;
    logic [U_WIDTH-1:0]     req_wu;
    // read response
    logic                   ack_vld;
    logic [TAG_WIDTH-1:0]   ack_tag;
    logic [PRED_WIDTH-1:0]  ack_pred;
    logic                   ack_valid;
    logic [U_WIDTH-1:0]     ack_u;
    // SRAM port
    logic                   mem_req_vld;
    logic                   mem_req_wren;
    logic [INDEX_WIDTH-1:0] mem_req_addr;
    logic [TAG_WIDTH-1:0]   mem_wtag;
    logic [PRED_WIDTH-1:0]  mem_wpred;
    logic                   mem_wvalid;
    logic [U_WIDTH-1:0]     mem_wu;
    logic [TAG_WIDTH-1:0]   mem_rtag;
    logic [PRED_WIDTH-1:0]  mem_rpred;
    logic                   mem_rvalid;
    logic [U_WIDTH-1:0]     mem_ru;

    modport slave (
        input  age_req, req_vld, req_wren, req_addr, req_wtag, req_wpred,
               req_wvalid, req_wu, mem_rtag, mem_rpred, mem_rvalid, mem_ru,
        output age_busy, age_drop, ack_vld, ack_tag, ack_pred, ack_valid,
               ack_u, mem_req_vld, mem_req_wren, mem_req_addr, mem_wtag,
               mem_wpred, mem_wvalid, mem_wu
    );

    modport master (
        output age_req, req_vld, req_wren, req_addr, req_wtag, req_wpred,
               req_wvalid, req_wu, mem_rtag, mem_rpred, mem_rvalid, mem_ru,
        input  age_busy, age_drop, ack_vld, ack_tag, ack_pred, ack_valid,
               ack_u, mem_req_vld, mem_req_wren, mem_req_addr, mem_wtag,
               mem_wpred, mem_wvalid, mem_wu
    );
endinterface
`default_nettype wire

// File: rtl/toy_bpu_tage_tx_table_ager.sv
`default_nettype none
// ============================================================================
//  Module   : toy_bpu_tage_tx_table_ager
//  Brief    : TAGE tagged-table front end. Passes entry fields to the SRAM,
//             ages useful counters lazily through a per-entry mask applied
//             on read. With TOY_BPU_TAGE_TX_SCRUB_EN defined, a background
//             scrubber writes aged u values back during idle port cycles and
//             one further age event can be deferred while it runs.
//  Revision : 1.0 - initial release
// ============================================================================
module toy_bpu_tage_tx_table_ager #(
    parameter int INDEX_WIDTH = 8,
    parameter int TAG_WIDTH   = 9,
    parameter int PRED_WIDTH  = 3,
    parameter int U_WIDTH     = 2,
    parameter int AGE_MODE    = 0
) (
    input  logic                           clk,
    input  logic                           rst_n,
    toy_bpu_tage_tx_table_ager_if.slave    bus
);
    localparam int DEPTH = 2**INDEX_WIDTH;

    // One aging step: mode 1 halves u; mode 0 clears the MSB on odd events
    // (phase 1) and the LSB on even events (phase 0). Never increases u.
    function automatic logic [U_WIDTH-1:0] f_age(input logic [U_WIDTH-1:0] u,
                                                 input logic ph);
        logic [U_WIDTH-1:0] r;
        r = u;
        if (AGE_MODE == 1) begin
            r = u >> 1;
        end else if (ph) begin
            r[U_WIDTH-1] = 1'b0;
        end else begin
            r[0] = 1'b0;
        end
        return r;
    endfunction

    logic [DEPTH-1:0] r_mask;
    logic             r_phase;
    logic             r_ack_vld;
    logic             r_rd_masked;
    logic             r_rd_phase;
    logic             w_age_accept;
    logic             w_req_wr;

    assign w_req_wr = bus.req_vld && bus.req_wren;

`ifdef TOY_BPU_TAGE_TX_SCRUB_EN
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    state_t                 r_state;
    logic [INDEX_WIDTH-1:0] r_ptr;
    logic                   r_deferred;
    logic                   r_age_busy;
    logic                   r_age_drop;
    logic                   w_step_done;
    logic                   w_scrub_wr;
    logic                   w_last_done;
    logic                   w_busy_req;

    // A WR step completes whenever the requester leaves the port free; the
    // write itself is skipped if the requester rewrote the entry meanwhile.
    assign w_step_done  = (r_state == ST_WR) && !bus.req_vld;
    assign w_scrub_wr   = w_step_done && r_mask[r_ptr];
    assign w_last_done  = w_step_done && (&r_ptr);
    assign w_busy_req   = bus.age_req && (r_state != ST_IDLE);
    assign w_age_accept = (bus.age_req && ((r_state == ST_IDLE) || w_last_done))
                        || (w_last_done && r_deferred);

    // Scrub sequencer: walks every entry, read then write-back, yielding to the requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_deferred <= 1'b0;
            r_age_busy <= 1'b0;
            r_age_drop <= 1'b0;
        end else begin
            r_age_drop <= w_busy_req && r_deferred && !w_last_done;
            if (w_last_done) begin
                r_deferred <= r_deferred && bus.age_req;
            end else if (w_busy_req) begin
                r_deferred <= 1'b1;
            end
            if (w_age_accept) begin
                r_state    <= ST_RD;
                r_ptr      <= '0;
                r_age_busy <= 1'b1;
            end else begin
                case (r_state)
                    ST_RD: begin
                        if (!bus.req_vld) begin
                            r_state <= ST_WR;
                        end
                    end
                    ST_WR: begin
                        if (bus.req_vld) begin
                            r_state <= ST_RD;
                        end else if (&r_ptr) begin
                            r_state    <= ST_IDLE;
                            r_age_busy <= 1'b0;
                        end else begin
                            r_state <= ST_RD;
                            r_ptr   <= r_ptr + INDEX_WIDTH'(1);
                        end
                    end
                    default: begin
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.age_busy = r_age_busy;
    assign bus.age_drop = r_age_drop;
`else
    logic w_scrub_wr;

    assign w_scrub_wr   = 1'b0;
    assign w_age_accept = bus.age_req;
    assign bus.age_busy = 1'b0;
    assign bus.age_drop = 1'b0;
`endif

    // Age mask and phase; an age event's set-all takes priority over any clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mask  <= '0;
            r_phase <= 1'b0;
        end else if (w_age_accept) begin
            r_mask  <= '1;
            r_phase <= ~r_phase;
        end else begin
            if (w_req_wr) begin
                r_mask[bus.req_addr] <= 1'b0;
            end
`ifdef TOY_BPU_TAGE_TX_SCRUB_EN
            if (w_scrub_wr) begin
                r_mask[r_ptr] <= 1'b0;
            end
`endif
        end
    end

    // Read pipeline: capture mask bit and phase at request time, pre-age.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack_vld   <= 1'b0;
            r_rd_masked <= 1'b0;
            r_rd_phase  <= 1'b0;
        end else begin
            r_ack_vld   <= bus.req_vld && !bus.req_wren;
            r_rd_masked <= r_mask[bus.req_addr];
            r_rd_phase  <= r_phase;
        end
    end

    assign bus.ack_vld   = r_ack_vld;
    assign bus.ack_tag   = r_ack_vld ? bus.mem_rtag   : '0;
    assign bus.ack_pred  = r_ack_vld ? bus.mem_rpred  : '0;
    assign bus.ack_valid = r_ack_vld ? bus.mem_rvalid : 1'b0;
    assign bus.ack_u     = !r_ack_vld ? '0 :
                           r_rd_masked ? f_age(bus.mem_ru, r_rd_phase) : bus.mem_ru;

    // SRAM port mux: requester always wins, scrubber uses leftover cycles.
    always_comb begin
        bus.mem_req_vld  = 1'b0;
        bus.mem_req_wren = 1'b0;
        bus.mem_req_addr = '0;
        bus.mem_wtag     = '0;
        bus.mem_wpred    = '0;
        bus.mem_wvalid   = 1'b0;
        bus.mem_wu       = '0;
        if (bus.req_vld) begin
            bus.mem_req_vld  = 1'b1;
            bus.mem_req_wren = bus.req_wren;
            bus.mem_req_addr = bus.req_addr;
            bus.mem_wtag     = bus.req_wtag;
            bus.mem_wpred    = bus.req_wpred;
            bus.mem_wvalid   = bus.req_wvalid;
            bus.mem_wu       = bus.req_wu;
        end
`ifdef TOY_BPU_TAGE_TX_SCRUB_EN
        else if (r_state == ST_RD) begin
            bus.mem_req_vld  = 1'b1;
            bus.mem_req_addr = r_ptr;
        end else if (w_scrub_wr) begin
            bus.mem_req_vld  = 1'b1;
            bus.mem_req_wren = 1'b1;
            bus.mem_req_addr = r_ptr;
            bus.mem_wtag     = bus.mem_rtag;
            bus.mem_wpred    = bus.mem_rpred;
            bus.mem_wvalid   = bus.mem_rvalid;
            bus.mem_wu       = f_age(bus.mem_ru, r_phase);
        end
`endif
    end

endmodule
`default_nettype wire
